// File: rtl/hall_input_filter_pkg.sv
// Shared BLDC Hall sensor types: the 3-bit Hall code (bit0=A, bit1=B, bit2=C)
// and the forward/backward adjacency of the six valid commutation states.
package hall_input_filter_pkg;

  typedef enum logic [2:0] {
    HALL_000 = 3'b000,  // invalid: all sensors low
    HALL_001 = 3'b001,
    HALL_010 = 3'b010,
    HALL_011 = 3'b011,
    HALL_100 = 3'b100,
    HALL_101 = 3'b101,
    HALL_110 = 3'b110,
    HALL_111 = 3'b111   // invalid: all sensors high
  } hall_states_t;

  // True for the six codes a healthy sensor set can produce.
  function automatic logic is_valid(hall_states_t s);
    return (s != HALL_000) && (s != HALL_111);
  endfunction

  // Forward rotation: 101 -> 001 -> 011 -> 010 -> 110 -> 100 -> 101.
  // Invalid codes map to themselves so they are never anyone's neighbour.
  function automatic hall_states_t next(hall_states_t s);
    case (s)
      HALL_101: return HALL_001;
      HALL_001: return HALL_011;
      HALL_011: return HALL_010;
      HALL_010: return HALL_110;
      HALL_110: return HALL_100;
      HALL_100: return HALL_101;
      default:  return s;
    endcase
  endfunction

  // Backward rotation, the inverse of next().
  function automatic hall_states_t prev(hall_states_t s);
    case (s)
      HALL_001: return HALL_101;
      HALL_011: return HALL_001;
      HALL_010: return HALL_011;
      HALL_110: return HALL_010;
      HALL_100: return HALL_110;
      HALL_101: return HALL_100;
      default:  return s;
    endcase
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-stage synchroniser for a bus of independent asynchronous bits.
module bit_synchronizer #(
  parameter int width = 1
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] meta;

  // Shift each raw bit through two flops to resolve metastability.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      // NOTE: non-blocking so both stages sample old values; blocking here
      // would collapse the chain into a single flop.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hall_input_filter.sv
// Hall sensor input conditioning: synchronise, debounce, classify each stable
// code as valid/invalid, flag non-adjacent jumps and persistent invalid codes.
module hall_input_filter
  import hall_input_filter_pkg::*;
#(
  parameter int clk_freq_hz        = 27_000_000,
  parameter int filter_cycles      = 27,
  parameter int invalid_timeout_ms = 10,
  parameter int skip_count_width   = 8
) (
  input  logic                        sys_clk,
  input  logic                        reset_n,
  input  logic [2:0]                  hall_raw,
  output hall_states_t                hall_values,
  output logic                        hall_valid,
  output logic                        hall_changed,
  output logic                        skip_error,
  output logic [skip_count_width-1:0] skip_count,
  output logic                        hall_fault
);

  localparam int invalid_timeout_raw   = clk_freq_hz / 1000 * invalid_timeout_ms;
  localparam int invalid_timeout_ticks = (invalid_timeout_raw < 1) ? 1 : invalid_timeout_raw;
  localparam int filt_w                = $clog2(filter_cycles + 1);
  localparam int tmr_w                 = $clog2(invalid_timeout_ticks + 1);

  localparam logic [filt_w-1:0] filt_max     = filt_w'(filter_cycles);
  localparam logic [tmr_w-1:0]  timeout_last = tmr_w'(invalid_timeout_ticks - 1);

  logic [2:0]        hall_sync;
  hall_states_t      sync_code;
  hall_states_t      candidate;
  logic [filt_w-1:0] stable_cnt;
  logic              accept;
  logic              accept_valid;
  logic              accept_invalid;
  logic              code_new;
  logic              code_skip;
  logic              timer_active;
  logic [tmr_w-1:0]  invalid_timer;

  bit_synchronizer #(
    .width (3)
  ) u_sync (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .d       (hall_raw),
    .q       (hall_sync)
  );

  assign sync_code = hall_states_t'(hall_sync);

  // Accept exactly once: on the edge where the counter steps onto filter_cycles.
  assign accept = (sync_code == candidate) && (stable_cnt == filt_max - 1'b1);

  // Track the candidate code and how long it has been stable.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate  <= HALL_000;
      stable_cnt <= '0;
    end else if (sync_code != candidate) begin
      candidate  <= sync_code;
      stable_cnt <= '0;
    end else if (stable_cnt != filt_max) begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  // Classify the accepted code against the currently published one.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    accept_valid   = 1'b0;
    accept_invalid = 1'b0;
    code_new       = 1'b0;
    code_skip      = 1'b0;
    if (accept) begin
      if (is_valid(candidate)) begin
        accept_valid = 1'b1;
        code_new     = (candidate != hall_values);
        code_skip    = hall_valid && code_new &&
                       (candidate != next(hall_values)) &&
                       (candidate != prev(hall_values));
      end else begin
        accept_invalid = 1'b1;
      end
    end
  end

  // Publish new valid codes and raise the change/skip pulses.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      hall_values  <= HALL_000;
      hall_valid   <= 1'b0;
      hall_changed <= 1'b0;
      skip_error   <= 1'b0;
      skip_count   <= '0;
    end else begin
      hall_changed <= 1'b0;
      skip_error   <= 1'b0;
      if (accept_valid && code_new) begin
        hall_values  <= candidate;
        hall_valid   <= 1'b1;
        hall_changed <= 1'b1;
        if (code_skip) begin
          skip_error <= 1'b1;
          if (skip_count != '1) begin
            skip_count <= skip_count + 1'b1;
          end
        end
      end
    end
  end

  // Time how long an accepted invalid code persists; any valid code clears it.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_active  <= 1'b0;
      invalid_timer <= '0;
      hall_fault    <= 1'b0;
    end else if (accept_valid) begin
      timer_active  <= 1'b0;
      invalid_timer <= '0;
      hall_fault    <= 1'b0;
    end else if (accept_invalid && !timer_active) begin
      timer_active  <= 1'b1;
      invalid_timer <= '0;
    end else if (timer_active && !hall_fault) begin
      if (invalid_timer == timeout_last) begin
        hall_fault <= 1'b1;
      end else begin
        invalid_timer <= invalid_timer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hall_input_filter.sv
// Scoreboard bench for hall_input_filter: expected hall_changed events (value,
// skip flag, edge number) are queued when stimulus is applied and matched by a
// monitor whenever the DUT pulses hall_changed.
module tb_hall_input_filter;
  import hall_input_filter_pkg::*;

  localparam int F      = 27;
  localparam int CLK_HZ = 100_000;
  localparam int TMO_MS = 10;
  localparam int SCW    = 8;
  localparam int T      = CLK_HZ / 1000 * TMO_MS;
  localparam int LAT    = F + 3;

  logic           sys_clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [2:0]     hall_raw = 3'b001;
  hall_states_t   hall_values;
  logic           hall_valid;
  logic           hall_changed;
  logic           skip_error;
  logic [SCW-1:0] skip_count;
  logic           hall_fault;

  hall_input_filter #(
    .clk_freq_hz        (CLK_HZ),
    .filter_cycles      (F),
    .invalid_timeout_ms (TMO_MS),
    .skip_count_width   (SCW)
  ) dut (
    .sys_clk      (sys_clk),
    .reset_n      (reset_n),
    .hall_raw     (hall_raw),
    .hall_values  (hall_values),
    .hall_valid   (hall_valid),
    .hall_changed (hall_changed),
    .skip_error   (skip_error),
    .skip_count   (skip_count),
    .hall_fault   (hall_fault)
  );

  always #5 sys_clk = ~sys_clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] val;
    logic       skip;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pulses = 0;

  // Reference model state.
  logic [2:0] m_val   = 3'b000;
  logic       m_valid = 1'b0;
  int         m_skips = 0;

  logic [2:0] fwd [6] = '{3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};

  function automatic logic tb_adjacent(logic [2:0] a, logic [2:0] b);
    int ia = -1;
    int ib = -1;
    for (int i = 0; i < 6; i++) begin
      if (fwd[i] == a) ia = i;
      if (fwd[i] == b) ib = i;
    end
    return ((ia + 1) % 6 == ib) || ((ib + 1) % 6 == ia);
  endfunction

  // Monitor: match every hall_changed pulse against the scoreboard head.
  always @(negedge sys_clk) begin
    exp_t e;
    if (hall_changed === 1'b1) begin
      n_pulses++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse edge=%0d hall_values=%b, expected no pulse", cyc, hall_values);
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (hall_values !== e.val) begin
          n_fail++;
          $display("FAIL pulse_value edge=%0d got=%b expected=%b", cyc, hall_values, e.val);
        end
        n_checks++;
        if (skip_error !== e.skip) begin
          n_fail++;
          $display("FAIL pulse_skip edge=%0d got=%b expected=%b", cyc, skip_error, e.skip);
        end
        n_checks++;
        if (cyc !== e.cyc) begin
          n_fail++;
          $display("FAIL pulse_latency got edge=%0d expected edge=%0d", cyc, e.cyc);
        end
      end
    end else if (skip_error === 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL lone_skip edge=%0d skip_error=1 without hall_changed", cyc);
    end
  end

  task automatic wait_until(input int target);
    @(negedge sys_clk);
    while (cyc < target) @(negedge sys_clk);
  endtask

  task automatic drive_raw(input logic [2:0] v, output int t);
    @(posedge sys_clk);
    #1;
    hall_raw = v;
    t = cyc;
  endtask

  // Drive a code, queue the pulse it should cause, then hold it.
  task automatic apply_code(input logic [2:0] v, input int hold, output int t);
    logic sk;
    drive_raw(v, t);
    if (v != 3'b000 && v != 3'b111 && (!m_valid || v != m_val)) begin
      sk = m_valid && !tb_adjacent(m_val, v);
      sb.push_back('{val: v, skip: sk, cyc: t + LAT});
      if (sk && m_skips < 255) m_skips++;
      m_val   = v;
      m_valid = 1'b1;
    end
    repeat (hold) @(posedge sys_clk);
  endtask

  task automatic drain(input string name);
    int budget = 4 * LAT;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge sys_clk);
      budget--;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_pulses pending=%0d expected=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    int t;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    n_checks++;
    if ({hall_values, hall_valid, hall_changed, skip_error, hall_fault, skip_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b/%b/%b/%b/%b/%0d expected all zero",
               hall_values, hall_valid, hall_changed, skip_error, hall_fault, skip_count);
    end
    @(posedge sys_clk);
    #1;
    reset_n = 1'b1;
    t = cyc;
    sb.push_back('{val: 3'b001, skip: 1'b0, cyc: t + LAT});
    m_val = 3'b001;
    m_valid = 1'b1;
    wait_until(t + LAT - 1);
    n_checks++;
    if (hall_valid !== 1'b0 || hall_values !== HALL_000) begin
      n_fail++;
      $display("FAIL first_code_early edge=%0d valid=%b values=%b expected 0/000", cyc, hall_valid, hall_values);
    end
    drain("first_code");
    n_checks++;
    if (hall_valid !== 1'b1 || hall_values !== HALL_001 || skip_count !== '0) begin
      n_fail++;
      $display("FAIL first_code valid=%b values=%b skips=%0d expected 1/001/0", hall_valid, hall_values, skip_count);
    end
  endtask

  task automatic test_glitch();
    int t;
    int p0 = n_pulses;
    drive_raw(3'b011, t);
    repeat (20) @(posedge sys_clk);
    drive_raw(3'b001, t);
    repeat (2 * LAT) @(posedge sys_clk);
    drain("glitch");
    @(negedge sys_clk);
    n_checks++;
    if (hall_values !== HALL_001 || n_pulses !== p0) begin
      n_fail++;
      $display("FAIL glitch values=%b pulses=%0d expected 001/%0d", hall_values, n_pulses, p0);
    end
  endtask

  task automatic test_full_cycle();
    logic [2:0] steps [12] = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001,
                               3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    int t;
    int p0 = n_pulses;
    for (int i = 0; i < 12; i++) apply_code(steps[i], 100, t);
    drain("full_cycle");
    n_checks++;
    if (n_pulses - p0 !== 12 || skip_count !== '0) begin
      n_fail++;
      $display("FAIL full_cycle pulses=%0d skips=%0d expected 12/0", n_pulses - p0, skip_count);
    end
  endtask

  task automatic test_skip();
    int t;
    apply_code(3'b110, LAT + 10, t);
    drain("skip_one");
    n_checks++;
    if (skip_count !== SCW'(1) || hall_values !== HALL_110) begin
      n_fail++;
      $display("FAIL skip_one skips=%0d values=%b expected 1/110", skip_count, hall_values);
    end
    for (int i = 0; i < 299; i++) apply_code((i % 2 == 0) ? 3'b001 : 3'b110, LAT + 3, t);
    drain("skip_sat");
    n_checks++;
    if (skip_count !== SCW'(m_skips)) begin
      n_fail++;
      $display("FAIL skip_saturate skips=%0d expected %0d", skip_count, m_skips);
    end
  endtask

  task automatic test_fault();
    int t;
    apply_code(3'b011, LAT + 10, t);
    drain("to_011");
    drive_raw(3'b111, t);
    wait_until(t + LAT + T - 1);
    n_checks++;
    if (hall_fault !== 1'b0 || hall_values !== HALL_011) begin
      n_fail++;
      $display("FAIL fault_early fault=%b values=%b expected 0/011", hall_fault, hall_values);
    end
    @(negedge sys_clk);
    n_checks++;
    if (hall_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_assert edge=%0d fault=%b expected 1", cyc, hall_fault);
    end
    repeat (70) @(posedge sys_clk);
    @(negedge sys_clk);
    n_checks++;
    if (hall_fault !== 1'b1 || hall_values !== HALL_011) begin
      n_fail++;
      $display("FAIL fault_hold fault=%b values=%b expected 1/011", hall_fault, hall_values);
    end
    apply_code(3'b010, 0, t);
    wait_until(t + LAT - 1);
    n_checks++;
    if (hall_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_before_clear fault=%b expected 1", hall_fault);
    end
    @(negedge sys_clk);
    n_checks++;
    if (hall_fault !== 1'b0 || hall_values !== HALL_010) begin
      n_fail++;
      $display("FAIL fault_clear fault=%b values=%b expected 0/010", hall_fault, hall_values);
    end
    drain("fault");
  endtask

  task automatic test_reset_mid();
    int t;
    drive_raw(3'b110, t);
    repeat (5) @(posedge sys_clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({hall_values, hall_valid, hall_changed, skip_error, hall_fault, skip_count} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got=%b/%b/%b/%b/%b/%0d expected all zero",
               hall_values, hall_valid, hall_changed, skip_error, hall_fault, skip_count);
    end
    m_val   = 3'b000;
    m_valid = 1'b0;
    m_skips = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    reset_n = 1'b1;
    t = cyc;
    sb.push_back('{val: 3'b110, skip: 1'b0, cyc: t + LAT});
    m_val   = 3'b110;
    m_valid = 1'b1;
    wait_until(t + LAT - 1);
    n_checks++;
    if (hall_valid !== 1'b0 || hall_values !== HALL_000) begin
      n_fail++;
      $display("FAIL reset_mid_early valid=%b values=%b expected 0/000", hall_valid, hall_values);
    end
    drain("reset_mid");
    n_checks++;
    if (hall_valid !== 1'b1 || hall_values !== HALL_110 || skip_count !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_after valid=%b values=%b skips=%0d expected 1/110/0",
               hall_valid, hall_values, skip_count);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog edge=%0d test did not complete", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_glitch();
    test_full_cycle();
    test_skip();
    test_fault();
    test_reset_mid();
    repeat (5) @(posedge sys_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
